// File: rtl/dep_rule_conf_seq.sv
// rtl/dep_rule_conf_seq.sv - deparser rule-config write sequencer (optional INVAL step: DEP_RULE_SEQ_INVALIDATE_EN)
module dep_rule_conf_seq #(
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 8,
    parameter int KEY_FILED_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 5,
    parameter int HEAD_SHIFT_WIDTH  = 8,
    parameter int META_SHIFT_WIDTH  = 8,
    parameter int RULE_ID_WIDTH     = 6
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_req_valid,
    output logic                                          o_req_ready,
    input  logic [RULE_ID_WIDTH-1:0]                      i_req_ruleId,
    input  logic                                          i_req_ruleValid,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_req_typeData,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_req_typeMask,
    input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         i_req_typeOffset,
    input  logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] i_req_keyOffset,
    input  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]     i_req_keyReplace,
    input  logic [HEAD_SHIFT_WIDTH-1:0]                   i_req_headShift,
    input  logic [META_SHIFT_WIDTH-1:0]                   i_req_metaShift,
    input  logic                                          i_abort,
    output logic                                          o_rule_wren,
    output logic [31:0]                                   o_rule_addr,
    output logic [31:0]                                   o_rule_wdata,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_aborted
);

    localparam int MAX_N = (TYPE_NUM > KEY_FILED_NUM) ? TYPE_NUM : KEY_FILED_NUM;
    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int KF_W  = KEY_OFFSET_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef DEP_RULE_SEQ_INVALIDATE_EN
        ST_INVAL,
`endif
        ST_TYPE,
        ST_TOFF,
        ST_KEY,
        ST_HSHIFT,
        ST_MSHIFT,
        ST_COMMIT
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               aborted_d;
    logic               wren_d, done_d;
    logic [31:0]        addr_d, wdata_d;
    logic [KF_W-1:0]    key_field;

    logic [RULE_ID_WIDTH-1:0]                      r_rule_id;
    logic                                          r_rule_valid;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]                r_type_data;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]                r_type_mask;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         r_type_offset;
    logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] r_key_offset;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]     r_key_replace;
    logic [HEAD_SHIFT_WIDTH-1:0]                   r_head_shift;
    logic [META_SHIFT_WIDTH-1:0]                   r_meta_shift;

    // The first write is registered on the accept edge, so it must be built from the live request
    logic                                          use_req;
    logic [RULE_ID_WIDTH-1:0]                      s_rule_id;
    logic                                          s_rule_valid;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]                s_type_data;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]                s_type_mask;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         s_type_offset;
    logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] s_key_offset;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]     s_key_replace;
    logic [HEAD_SHIFT_WIDTH-1:0]                   s_head_shift;
    logic [META_SHIFT_WIDTH-1:0]                   s_meta_shift;

    assign use_req       = (state == ST_IDLE);
    assign s_rule_id     = use_req ? i_req_ruleId     : r_rule_id;
    assign s_rule_valid  = use_req ? i_req_ruleValid  : r_rule_valid;
    assign s_type_data   = use_req ? i_req_typeData   : r_type_data;
    assign s_type_mask   = use_req ? i_req_typeMask   : r_type_mask;
    assign s_type_offset = use_req ? i_req_typeOffset : r_type_offset;
    assign s_key_offset  = use_req ? i_req_keyOffset  : r_key_offset;
    assign s_key_replace = use_req ? i_req_keyReplace : r_key_replace;
    assign s_head_shift  = use_req ? i_req_headShift  : r_head_shift;
    assign s_meta_shift  = use_req ? i_req_metaShift  : r_meta_shift;

    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);

    // Snapshot the whole request on accept; inputs are ignored until back in IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rule_id     <= '0;
            r_rule_valid  <= 1'b0;
            r_type_data   <= '0;
            r_type_mask   <= '0;
            r_type_offset <= '0;
            r_key_offset  <= '0;
            r_key_replace <= '0;
            r_head_shift  <= '0;
            r_meta_shift  <= '0;
        end else if (use_req && i_req_valid) begin
            r_rule_id     <= i_req_ruleId;
            r_rule_valid  <= i_req_ruleValid;
            r_type_data   <= i_req_typeData;
            r_type_mask   <= i_req_typeMask;
            r_type_offset <= i_req_typeOffset;
            r_key_offset  <= i_req_keyOffset;
            r_key_replace <= i_req_keyReplace;
            r_head_shift  <= i_req_headShift;
            r_meta_shift  <= i_req_metaShift;
        end
    end

    // Next state / index; abort drops straight to IDLE unless the commit is already out
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        aborted_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
`ifdef DEP_RULE_SEQ_INVALIDATE_EN
                    state_d = ST_INVAL;
`else
                    state_d = ST_TYPE;
`endif
                    idx_d = '0;
                end
            end
`ifdef DEP_RULE_SEQ_INVALIDATE_EN
            ST_INVAL: begin
                state_d = ST_TYPE;
                idx_d   = '0;
            end
`endif
            ST_TYPE: begin
                if (idx == IDX_W'(TYPE_NUM - 1)) begin
                    state_d = ST_TOFF;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            ST_TOFF: begin
                if (idx == IDX_W'(TYPE_NUM - 1)) begin
                    state_d = ST_KEY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            ST_KEY: begin
                if (idx == IDX_W'(KEY_FILED_NUM - 1)) begin
                    state_d = ST_HSHIFT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            ST_HSHIFT: state_d = ST_MSHIFT;
            ST_MSHIFT: state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (i_abort && (state != ST_IDLE) && (state != ST_COMMIT)) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            aborted_d = 1'b1;
        end
    end

    // Decode the write belonging to the state being entered, so it is registered on that edge
    always_comb begin
        wren_d    = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        done_d    = 1'b0;
        key_field = s_key_offset[int'(idx_d)*KF_W +: KF_W];
        case (state_d)
`ifdef DEP_RULE_SEQ_INVALIDATE_EN
            ST_INVAL: begin
                wren_d = 1'b1;
                addr_d = 32'(s_rule_id);
            end
`endif
            ST_TYPE: begin
                wren_d                    = 1'b1;
                addr_d                    = 32'h100 | 32'(idx_d);
                wdata_d[16 +: TYPE_WIDTH] = s_type_data[int'(idx_d)*TYPE_WIDTH +: TYPE_WIDTH];
                wdata_d[0 +: TYPE_WIDTH]  = s_type_mask[int'(idx_d)*TYPE_WIDTH +: TYPE_WIDTH];
            end
            ST_TOFF: begin
                wren_d                          = 1'b1;
                addr_d                          = 32'h200 | 32'(idx_d);
                wdata_d[0 +: TYPE_OFFSET_WIDTH] = s_type_offset[int'(idx_d)*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH];
            end
            ST_KEY: begin
                wren_d                         = 1'b1;
                addr_d                         = 32'h300 | 32'(idx_d);
                wdata_d[16]                    = key_field[KEY_OFFSET_WIDTH];
                wdata_d[8 +: KEY_OFFSET_WIDTH] = s_key_replace[int'(idx_d)*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH];
                wdata_d[0 +: KEY_OFFSET_WIDTH] = key_field[KEY_OFFSET_WIDTH-1:0];
            end
            ST_HSHIFT: begin
                wren_d  = 1'b1;
                addr_d  = 32'h400;
                wdata_d = 32'(s_head_shift);
            end
            ST_MSHIFT: begin
                wren_d  = 1'b1;
                addr_d  = 32'h500;
                wdata_d = 32'(s_meta_shift);
            end
            ST_COMMIT: begin
                wren_d     = 1'b1;
                addr_d     = 32'(s_rule_id);
                wdata_d[0] = s_rule_valid;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // State, index and registered write-port outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            o_rule_wren  <= 1'b0;
            o_rule_addr  <= '0;
            o_rule_wdata <= '0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            o_rule_wren  <= wren_d;
            o_rule_addr  <= addr_d;
            o_rule_wdata <= wdata_d;
            o_done       <= done_d;
            o_aborted    <= aborted_d;
        end
    end

endmodule

// File: tb/tb_dep_rule_conf_seq.sv
// tb/tb_dep_rule_conf_seq.sv - self-checking bench for dep_rule_conf_seq
module tb_dep_rule_conf_seq;

    localparam int TN  = 4;
    localparam int TW  = 16;
    localparam int TOW = 8;
    localparam int KN  = 8;
    localparam int KOW = 5;
    localparam int HW  = 8;
    localparam int MW  = 8;
    localparam int RW  = 6;
`ifdef DEP_RULE_SEQ_INVALIDATE_EN
    localparam int INV = 1;
`else
    localparam int INV = 0;
`endif
    localparam int NWR = 2*TN + KN + 3 + INV;

    logic                    clk;
    logic                    rst_n;
    logic                    i_req_valid;
    logic                    o_req_ready;
    logic [RW-1:0]           i_req_ruleId;
    logic                    i_req_ruleValid;
    logic [TN*TW-1:0]        i_req_typeData;
    logic [TN*TW-1:0]        i_req_typeMask;
    logic [TN*TOW-1:0]       i_req_typeOffset;
    logic [KN*(KOW+1)-1:0]   i_req_keyOffset;
    logic [KN*KOW-1:0]       i_req_keyReplace;
    logic [HW-1:0]           i_req_headShift;
    logic [MW-1:0]           i_req_metaShift;
    logic                    i_abort;
    logic                    o_rule_wren;
    logic [31:0]             o_rule_addr;
    logic [31:0]             o_rule_wdata;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_aborted;

    dep_rule_conf_seq dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_ruleId     (i_req_ruleId),
        .i_req_ruleValid  (i_req_ruleValid),
        .i_req_typeData   (i_req_typeData),
        .i_req_typeMask   (i_req_typeMask),
        .i_req_typeOffset (i_req_typeOffset),
        .i_req_keyOffset  (i_req_keyOffset),
        .i_req_keyReplace (i_req_keyReplace),
        .i_req_headShift  (i_req_headShift),
        .i_req_metaShift  (i_req_metaShift),
        .i_abort          (i_abort),
        .o_rule_wren      (o_rule_wren),
        .o_rule_addr      (o_rule_addr),
        .o_rule_wdata     (o_rule_wdata),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_aborted        (o_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    logic [RW-1:0]  m_id;
    logic           m_valid;
    logic [TW-1:0]  m_td[TN];
    logic [TW-1:0]  m_tm[TN];
    logic [TOW-1:0] m_to[TN];
    logic           m_kv[KN];
    logic [KOW-1:0] m_ko[KN];
    logic [KOW-1:0] m_kr[KN];
    logic [HW-1:0]  m_hs;
    logic [MW-1:0]  m_ms;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected write list, built field by field from the rule contents
    task automatic build_model();
        exp_addr.delete();
        exp_data.delete();
        if (INV == 1) begin
            exp_addr.push_back(32'(m_id));
            exp_data.push_back(32'd0);
        end
        for (int i = 0; i < TN; i++) begin
            exp_addr.push_back(32'h100 + 32'(i));
            exp_data.push_back(32'(m_td[i]) * 32'h10000 + 32'(m_tm[i]));
        end
        for (int i = 0; i < TN; i++) begin
            exp_addr.push_back(32'h200 + 32'(i));
            exp_data.push_back(32'(m_to[i]));
        end
        for (int i = 0; i < KN; i++) begin
            exp_addr.push_back(32'h300 + 32'(i));
            exp_data.push_back((m_kv[i] ? 32'h10000 : 32'h0) + 32'(m_kr[i]) * 32'd256 + 32'(m_ko[i]));
        end
        exp_addr.push_back(32'h400);
        exp_data.push_back(32'(m_hs));
        exp_addr.push_back(32'h500);
        exp_data.push_back(32'(m_ms));
        exp_addr.push_back(32'(m_id));
        exp_data.push_back(32'(m_valid));
    endtask

    task automatic randomize_model();
        m_id    = RW'($urandom);
        m_valid = 1'($urandom);
        for (int i = 0; i < TN; i++) begin
            m_td[i] = TW'($urandom);
            m_tm[i] = TW'($urandom);
            m_to[i] = TOW'($urandom);
        end
        for (int i = 0; i < KN; i++) begin
            m_kv[i] = 1'($urandom);
            m_ko[i] = KOW'($urandom);
            m_kr[i] = KOW'($urandom);
        end
        m_hs = HW'($urandom);
        m_ms = MW'($urandom);
    endtask

    task automatic zero_model();
        m_id    = '0;
        m_valid = 1'b0;
        for (int i = 0; i < TN; i++) begin
            m_td[i] = '0;
            m_tm[i] = '0;
            m_to[i] = '0;
        end
        for (int i = 0; i < KN; i++) begin
            m_kv[i] = 1'b0;
            m_ko[i] = '0;
            m_kr[i] = '0;
        end
        m_hs = '0;
        m_ms = '0;
    endtask

    task automatic drive_req();
        i_req_ruleId    = m_id;
        i_req_ruleValid = m_valid;
        for (int i = 0; i < TN; i++) begin
            i_req_typeData[i*TW +: TW]     = m_td[i];
            i_req_typeMask[i*TW +: TW]     = m_tm[i];
            i_req_typeOffset[i*TOW +: TOW] = m_to[i];
        end
        for (int i = 0; i < KN; i++) begin
            i_req_keyOffset[i*(KOW+1) +: KOW+1] = {m_kv[i], m_ko[i]};
            i_req_keyReplace[i*KOW +: KOW]      = m_kr[i];
        end
        i_req_headShift = m_hs;
        i_req_metaShift = m_ms;
    endtask

    task automatic scramble_inputs();
        i_req_ruleId     = RW'($urandom);
        i_req_ruleValid  = 1'($urandom);
        i_req_typeData   = {$urandom, $urandom};
        i_req_typeMask   = {$urandom, $urandom};
        i_req_typeOffset = $urandom;
        i_req_keyOffset  = 48'({$urandom, $urandom});
        i_req_keyReplace = 40'({$urandom, $urandom});
        i_req_headShift  = HW'($urandom);
        i_req_metaShift  = MW'($urandom);
    endtask

    // Called at a negedge with the DUT idle; presents the model rule and follows its writes
    task automatic run_req(input int abort_at, input int reset_at);
        int n;
        build_model();
        n = exp_addr.size();
        obs_addr.delete();
        obs_data.delete();
        check("ready_before_accept", 32'(o_req_ready), 32'd1);
        drive_req();
        i_req_valid = 1'b1;
        i_abort     = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            scramble_inputs();
            i_req_valid = 1'($urandom);
            i_abort     = 1'b0;
            obs_addr.push_back(o_rule_addr);
            obs_data.push_back(o_rule_wdata);
            check($sformatf("wren[%0d]", k), 32'(o_rule_wren), 32'd1);
            check($sformatf("addr[%0d]", k), o_rule_addr, exp_addr[k]);
            check($sformatf("data[%0d]", k), o_rule_wdata, exp_data[k]);
            check($sformatf("done[%0d]", k), 32'(o_done), 32'(k == n - 1));
            check($sformatf("busy[%0d]", k), 32'(o_busy), 32'd1);
            check($sformatf("ready[%0d]", k), 32'(o_req_ready), 32'd0);
            check($sformatf("aborted[%0d]", k), 32'(o_aborted), 32'd0);
            if (k == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_wren", 32'(o_rule_wren), 32'd0);
                check("rst_busy", 32'(o_busy), 32'd0);
                check("rst_ready", 32'(o_req_ready), 32'd1);
                check("rst_done", 32'(o_done), 32'd0);
                @(negedge clk);
                rst_n       = 1'b1;
                i_req_valid = 1'b0;
                return;
            end
            if (k == abort_at) begin
                i_abort = 1'b1;
                if (k < n - 1) begin
                    @(negedge clk);
                    i_abort     = 1'b0;
                    i_req_valid = 1'b0;
                    check("abort_wren", 32'(o_rule_wren), 32'd0);
                    check("abort_done", 32'(o_done), 32'd0);
                    check("abort_pulse", 32'(o_aborted), 32'd1);
                    check("abort_ready", 32'(o_req_ready), 32'd1);
                    check("abort_busy", 32'(o_busy), 32'd0);
                    @(negedge clk);
                    check("abort_pulse_end", 32'(o_aborted), 32'd0);
                    check("abort_no_more_wr", 32'(o_rule_wren), 32'd0);
                    return;
                end
            end
        end
        @(negedge clk);
        i_req_valid = 1'b0;
        i_abort     = 1'b0;
        check("end_wren", 32'(o_rule_wren), 32'd0);
        check("end_done", 32'(o_done), 32'd0);
        check("end_busy", 32'(o_busy), 32'd0);
        check("end_ready", 32'(o_req_ready), 32'd1);
        check("end_aborted", 32'(o_aborted), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        i_abort     = 1'b0;
        zero_model();
        drive_req();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_wren", 32'(o_rule_wren), 32'd0);
            check("idle_ready", 32'(o_req_ready), 32'd1);
            check("idle_busy", 32'(o_busy), 32'd0);
            check("idle_done", 32'(o_done), 32'd0);
        end

        // Directed rule: id 5, type0 0x0800/0xFFFF, key0 valid off 3 repl 7
        zero_model();
        m_id    = 6'd5;
        m_valid = 1'b1;
        m_td[0] = 16'h0800;
        m_tm[0] = 16'hFFFF;
        m_kv[0] = 1'b1;
        m_ko[0] = 5'd3;
        m_kr[0] = 5'd7;
        run_req(-1, -1);
        check("dir_count", 32'(obs_addr.size()), 32'(NWR));
        check("dir_w0_addr", obs_addr[INV], 32'h100);
        check("dir_w0_data", obs_data[INV], 32'h0800FFFF);
        check("dir_key0_addr", obs_addr[INV + 2*TN], 32'h300);
        check("dir_key0_data", obs_data[INV + 2*TN], 32'h00010703);
        check("dir_commit_addr", obs_addr[NWR - 1], 32'h005);
        check("dir_commit_data", obs_data[NWR - 1], 32'h1);

`ifdef DEP_RULE_SEQ_INVALIDATE_EN
        zero_model();
        m_id    = 6'd3;
        m_valid = 1'b1;
        run_req(-1, -1);
        check("inv_first_addr", obs_addr[0], 32'h003);
        check("inv_first_data", obs_data[0], 32'h0);
        check("inv_commit_data", obs_data[NWR - 1], 32'h1);
`endif

        // Back-to-back requests, ids 1 then 2
        randomize_model();
        m_id = 6'd1;
        run_req(-1, -1);
        randomize_model();
        m_id = 6'd2;
        run_req(-1, -1);

        // Abort on the 10th write
        randomize_model();
        run_req(9, -1);

        // Abort coinciding with commit is ignored
        randomize_model();
        run_req(NWR - 1, -1);

        // Abort while idle is ignored
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("idle_abort_ready", 32'(o_req_ready), 32'd1);
        check("idle_abort_pulse", 32'(o_aborted), 32'd0);
        check("idle_abort_wren", 32'(o_rule_wren), 32'd0);

        // Async reset mid-sequence, then a full sequence
        randomize_model();
        run_req(-1, 6);
        randomize_model();
        run_req(-1, -1);

        // Random rules
        for (int r = 0; r < 6; r++) begin
            randomize_model();
            run_req(-1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
